layer_three: RTL and testbench
==============================

# layer_three

Final fully-connected binary classification stage of the MNIST BNN. It consumes the 4×7×7 binary feature map produced by the second convolution/pool stage and computes one XNOR-popcount score per digit class, 0–9. It processes one 49-bit filter plane per cycle. After all classes are scored it reports the arg-max class as the predicted digit, alongside the per-class scores. It runs while the top-level FSM is in s_LAYER_3 and raises `done` for the top level.

## Interface
- N_CLASSES, 10, number of output classes
- N_PLANES, 4, feature planes (filters) from the previous stage
- PLANE_BITS, 49, bits per plane (7×7)
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- state  input  3  top-level state; block advances only when state == 3'b100 (s_LAYER_3)
- features  input  [3:0][6:0][6:0]  binary feature map; plane p, row r, col c; held stable by upstream for the whole run
- weights  input  [9:0][3:0][48:0]  binary dense weights; class k, plane p, bit r*7+c pairs with features[p][r][c]
- class_scores  output  [9:0][7:0]  registered popcount score per class, 0..196
- digit  output  4  registered predicted class, 0..9
- max_score  output  8  registered score of `digit`
- done  output  1  high once classification is complete; sticky until reset

## Operation
- Score(k) = Σ over p,r,c of XNOR(features[p][r][c], weights[k][p][r*7+c]). Range is 0..196, held in 8 bits unsigned with no overflow possible. This is equivalent to the ±1 dot product 2·Score − 196.
- Internal registers:
  - class counter `cls` (0..9)
  - plane counter `pl` (0..3)
  - accumulator `acc` (8 bit)
  - FSM with states IDLE, ACCUM, COMPARE, FINISH
- IDLE: on an edge with state==s_LAYER_3, clear acc/cls/pl and go to ACCUM.
- ACCUM: add acc += popcount(~(features[pl] ^ weights[cls][pl])), a 6-bit value 0..49.
  - If pl<3: pl++.
  - If pl==3: go to COMPARE, with pl cleared.
- COMPARE: write class_scores[cls] <= acc. Update the running maximum:
  - If cls==0 or acc > max_score (strictly greater): max_score <= acc, digit <= cls.
  - Ties therefore resolve to the lowest class index.
  - Clear acc.
  - If cls<9: cls++ and return to ACCUM.
  - Else: go to FINISH with done <= 1 on the same edge.
- FINISH: all outputs hold. done stays 1 regardless of `state`. Only reset leaves FINISH.
- Pause: on any edge with state != s_LAYER_3 while in ACCUM or COMPARE, all registers hold. Work resumes exactly where it stopped.
- class_scores entries not yet written keep their reset value 0.

## Timing
- Reset values: class_scores all 0, digit 0, max_score 0, done 0, FSM IDLE, acc/cls/pl 0.
- Reset has priority over everything, including mid-run and in FINISH. Applying it returns the block to IDLE with all outputs at reset values on the next edge.
- Uninterrupted run latency:
  - Edge 1 (first edge with state==s_LAYER_3): IDLE→ACCUM.
  - Then 4 ACCUM + 1 COMPARE edge per class, i.e. 50 edges.
  - done is first high after edge 51. digit, max_score and class_scores are final at that same edge.
- Paused edges add one cycle each to the latency and do not change the result.
- class_scores[k] becomes valid after edge 1 + 5(k+1).
- No combinational path from inputs to outputs. The popcount (49-input) plus 8-bit add is the single-cycle critical path.

## Test plan
- Class 3's weights equal `features` bit-for-bit, and every other class's weights equal ~features → digit=3, max_score=196, class_scores[3]=196, all other scores 0, done high exactly after edge 51.
- All weights identical for every class, features random → all class_scores equal; digit=0 (tie rule).
- Class scores are built so class 9 scores 150, class 4 scores 149, and the rest score ≤100 → digit=9, max_score=150, class_scores[4]=149.
- Same stimulus as the first scenario, but state is driven to 3'b011 for 7 cycles after edge 20 → identical outputs, done first high after edge 58.
- rst_n pulled low for one edge at edge 30, then state==s_LAYER_3 continuously → all outputs 0 the edge after reset; the rerun completes 51 edges after reset release with the correct digit.
- After done, change features/weights and toggle state → digit, max_score, class_scores and done remain unchanged.

Source files
------------

// File: rtl/layer_three.sv
// Final fully-connected BNN stage: one XNOR-popcount score per digit class,
// one 49-bit feature plane per cycle, then arg-max over the ten class scores.
module layer_three (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            state,
    input  logic [3:0][6:0][6:0]  features,
    input  logic [9:0][3:0][48:0] weights,
    output logic [9:0][7:0]       class_scores,
    output logic [3:0]            digit,
    output logic [7:0]            max_score,
    output logic                  done
);

    localparam logic [2:0] S_LAYER_3 = 3'b100;
    localparam logic [3:0] LAST_CLS  = 4'd9;
    localparam logic [1:0] LAST_PL   = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        COMPARE,
        FINISH
    } fsm_t;

    fsm_t       fsm;
    logic [3:0] cls;
    logic [1:0] pl;
    logic [7:0] acc;
    logic       run;

    logic [48:0] match;
    logic [5:0]  plane_pop;

    assign run = (state == S_LAYER_3);

    // A plane is stored row-major, so plane bit r*7+c lines up with features[p][r][c].
    // NOTE: every always_comb output gets a default before the loop so no latch is inferred.
    always_comb begin
        match     = ~(features[pl] ^ weights[cls][pl]);
        plane_pop = '0;
        for (int i = 0; i < 49; i++) begin
            plane_pop = plane_pop + 6'(match[i]);
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm          <= IDLE;
            cls          <= '0;
            pl           <= '0;
            acc          <= '0;
            class_scores <= '0;
            digit        <= '0;
            max_score    <= '0;
            done         <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (run) begin
                        acc <= '0;
                        cls <= '0;
                        pl  <= '0;
                        fsm <= ACCUM;
                    end
                end

                ACCUM: begin
                    if (run) begin
                        acc <= acc + 8'(plane_pop);
                        if (pl == LAST_PL) begin
                            pl  <= '0;
                            fsm <= COMPARE;
                        end else begin
                            pl <= pl + 2'd1;
                        end
                    end
                end

                COMPARE: begin
                    if (run) begin
                        class_scores[cls] <= acc;
                        // Strict compare: ties keep the lower class index.
                        if (cls == 4'd0 || acc > max_score) begin
                            max_score <= acc;
                            digit     <= cls;
                        end
                        acc <= '0;
                        if (cls == LAST_CLS) begin
                            done <= 1'b1;
                            fsm  <= FINISH;
                        end else begin
                            cls <= cls + 4'd1;
                            fsm <= ACCUM;
                        end
                    end
                end

                FINISH: begin
                    // Results and done are held until reset.
                end

                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_three.sv
// Randomized self-checking bench for layer_three: scores, arg-max and done
// timing are checked against a plain-arithmetic model of the classifier.
module tb_layer_three;

    logic                  clk;
    logic                  rst_n;
    logic [2:0]            state;
    logic [3:0][6:0][6:0]  features;
    logic [9:0][3:0][48:0] weights;
    logic [9:0][7:0]       class_scores;
    logic [3:0]            digit;
    logic [7:0]            max_score;
    logic                  done;

    int n_checks = 0;
    int n_pass   = 0;

    int exp_scores[10];
    int exp_digit;
    int exp_max;

    layer_three dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .state        (state),
        .features     (features),
        .weights      (weights),
        .class_scores (class_scores),
        .digit        (digit),
        .max_score    (max_score),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Score = number of positions where feature and weight bits agree.
    task automatic compute_model();
        for (int k = 0; k < 10; k++) begin
            exp_scores[k] = 0;
            for (int p = 0; p < 4; p++)
                for (int r = 0; r < 7; r++)
                    for (int c = 0; c < 7; c++)
                        if (features[p][r][c] == weights[k][p][r*7+c]) exp_scores[k]++;
        end
        exp_digit = 0;
        exp_max   = exp_scores[0];
        for (int k = 1; k < 10; k++) begin
            if (exp_scores[k] > exp_max) begin
                exp_max   = exp_scores[k];
                exp_digit = k;
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_digit"}, int'(digit), 0);
        check({tag, "_max"}, int'(max_score), 0);
        for (int k = 0; k < 10; k++)
            check($sformatf("%s_score%0d", tag, k), int'(class_scores[k]), 0);
    endtask

    task automatic check_final(input string tag);
        check({tag, "_done"}, int'(done), 1);
        check({tag, "_digit"}, int'(digit), exp_digit);
        check({tag, "_max"}, int'(max_score), exp_max);
        for (int k = 0; k < 10; k++)
            check($sformatf("%s_score%0d", tag, k), int'(class_scores[k]), exp_scores[k]);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        state = 3'b000;
        step();
        step();
        check_reset_vals(tag);
        rst_n = 1'b1;
        state = 3'b100;
    endtask

    // Runs from IDLE with state already at s_LAYER_3; edges pause_start+1 ..
    // pause_start+pause_len see a different state value.
    task automatic run_and_check(input string tag, input int pause_start, input int pause_len);
        int first_done = 0;
        compute_model();
        for (int e = 1; e <= 200 && first_done == 0; e++) begin
            step();
            if (done) first_done = e;
            if (pause_len == 0) begin
                for (int k = 0; k < 10; k++)
                    if (e == 1 + 5 * (k + 1))
                        check($sformatf("%s_partial%0d", tag, k), int'(class_scores[k]), exp_scores[k]);
            end
            if (e + 1 > pause_start && e + 1 <= pause_start + pause_len) state = 3'b011;
            else state = 3'b100;
        end
        check({tag, "_done_edge"}, first_done, 51 + pause_len);
        check_final(tag);
    endtask

    task automatic rand_features();
        for (int p = 0; p < 4; p++)
            for (int r = 0; r < 7; r++)
                for (int c = 0; c < 7; c++)
                    features[p][r][c] = 1'($urandom_range(0, 1));
    endtask

    task automatic rand_weights();
        for (int k = 0; k < 10; k++)
            for (int p = 0; p < 4; p++)
                for (int b = 0; b < 49; b++)
                    weights[k][p][b] = 1'($urandom_range(0, 1));
    endtask

    // Class 3 copies the features exactly; every other class is their complement.
    task automatic stim_match3();
        rand_features();
        for (int k = 0; k < 10; k++)
            for (int p = 0; p < 4; p++)
                weights[k][p] = (k == 3) ? features[p] : ~features[p];
    endtask

    // Each class agrees with the features on exactly target[k] bit positions.
    task automatic stim_targets();
        int target;
        rand_features();
        for (int k = 0; k < 10; k++) begin
            target = (k == 9) ? 150 : (k == 4) ? 149 : int'($urandom_range(0, 100));
            for (int i = 0; i < 196; i++) begin
                logic fbit;
                fbit = features[i / 49][(i % 49) / 7][(i % 49) % 7];
                weights[k][i / 49][i % 49] = (i < 196 - target) ? ~fbit : fbit;
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        state    = 3'b000;
        features = '0;
        weights  = '0;

        // Exact match on class 3.
        stim_match3();
        do_reset("rst1");
        run_and_check("match3", 0, 0);
        check("match3_digit_abs", int'(digit), 3);
        check("match3_max_abs", int'(max_score), 196);

        // Identical weights for every class: full tie resolves to class 0.
        rand_features();
        for (int p = 0; p < 4; p++)
            for (int b = 0; b < 49; b++)
                weights[0][p][b] = 1'($urandom_range(0, 1));
        for (int k = 1; k < 10; k++) weights[k] = weights[0];
        do_reset("rst2");
        run_and_check("tie", 0, 0);
        check("tie_digit_abs", int'(digit), 0);

        // Close race between class 9 (150) and class 4 (149).
        stim_targets();
        do_reset("rst3");
        run_and_check("near", 0, 0);
        check("near_digit_abs", int'(digit), 9);
        check("near_max_abs", int'(max_score), 150);
        check("near_score4_abs", int'(class_scores[4]), 149);

        // Pause for 7 edges after edge 20.
        stim_match3();
        do_reset("rst4");
        run_and_check("pause", 20, 7);

        // Reset at edge 30 mid-run, then a clean rerun.
        stim_targets();
        do_reset("rst5");
        for (int e = 1; e < 30; e++) step();
        rst_n = 1'b0;
        step();
        check_reset_vals("midrst");
        rst_n = 1'b1;
        run_and_check("rerun", 0, 0);

        // After done, input changes and state toggling must not disturb results.
        for (int i = 0; i < 20; i++) begin
            state = 3'($urandom_range(0, 7));
            rand_features();
            rand_weights();
            step();
        end
        check_final("hold");

        // Fully random runs.
        for (int t = 0; t < 3; t++) begin
            rand_features();
            rand_weights();
            do_reset($sformatf("rst_r%0d", t));
            run_and_check($sformatf("rand%0d", t), 0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
